// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte write delivery and read service.
// Latency: pin to condition detect SYNC_STAGES+1 clk; never stretches SCL, so the master is never held off.
module i2c_slave #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed,
    output logic       busy,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s, rise_c, fall_c, start_c, stop_c;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d, nack_q, nack_d;
    logic       sda_oe_q, sda_oe_d, addressed_q, addressed_d, busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, stop_det_q, stop_det_d, tx_load_c;

    // Presetting to 1 means an idle bus at reset release looks like no change at all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s   = scl_sync_q[SYNC_STAGES-1];
    assign sda_s   = sda_sync_q[SYNC_STAGES-1];
    assign rise_c  = scl_s & ~scl_hist_q;
    assign fall_c  = ~scl_s & scl_hist_q;
    assign start_c = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_c  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            stop_det_q  <= stop_det_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        sda_oe_d    = sda_oe_q;
        addressed_d = addressed_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        stop_det_d  = 1'b0;
        tx_load_c   = 1'b0;
        if (start_c) begin
            state_d     = S_ADDR;
            cnt_d       = 4'd0;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_c) begin
            state_d     = S_IDLE;
            sda_oe_d    = 1'b0;
            addressed_d = 1'b0;
            busy_d      = 1'b0;
            stop_det_d  = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (rise_c && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_c && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == ADDR) begin
                            sda_oe_d    = 1'b1;
                            addressed_d = 1'b1;
                            rw_d        = shift_q[0];
                            state_d     = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK, S_WRITE_ACK: begin
                    if (fall_c) begin
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            tx_load_c = 1'b1;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                            cnt_d     = 4'd1;
                            state_d   = S_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (rise_c && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (fall_c && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_WRITE_ACK;
                    end
                end
                // cnt counts bits already placed on the bus; shift_q[7] is the bit being driven.
                S_READ: begin
                    if (fall_c) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_READ_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                S_READ_ACK: begin
                    if (rise_c) begin
                        nack_d = sda_s;
                    end else if (fall_c) begin
                        if (!nack_q) begin
                            tx_load_c = 1'b1;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                            cnt_d     = 4'd1;
                            state_d   = S_READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_c;
    assign addressed = addressed_q;
    assign busy      = busy_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: behavioural open-drain I2C master at 400 kHz against a 100 MHz core clock.
// Expected bytes are queued at stimulus time; monitor processes pop and compare as the DUT presents them.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam time TCLK = 10;
    localparam time Q    = 625;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_load, addressed, busy, stop_det;
    logic [7:0] rx_data;

    assign sda_bus = sda_m & ~sda_oe;
    always #(TCLK/2) clk = ~clk;

    i2c_slave #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
        .addressed(addressed), .busy(busy), .stop_det(stop_det)
    );

    int n_chk = 0, n_pass = 0;
    int n_stop = 0, n_txload = 0, n_oe_rise = 0, n_busy_fall = 0, n_addr_rise = 0, n_rx = 0, n_viol = 0;
    logic [7:0] exp_rx[$], exp_rd[$], obs_rd[$];
    logic oe_prev = 1'b0, busy_prev = 1'b0, addr_prev = 1'b0;
    logic last_oe = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Received-byte scoreboard and event counters.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx++;
            if (exp_rx.size() == 0) begin
                n_chk++;
                $display("FAIL rx_unexpected: got rx_data 0x%0h, no byte expected", rx_data);
            end else chk("rx_data", rx_data, exp_rx.pop_front());
        end
        if (tx_load) n_txload++;
        if (stop_det) n_stop++;
        if (sda_oe && !oe_prev) n_oe_rise++;
        if (rst_n && (sda_oe !== oe_prev) && scl) n_viol++;
        if (!busy && busy_prev) n_busy_fall++;
        if (addressed && !addr_prev) n_addr_rise++;
        oe_prev   = sda_oe;
        busy_prev = busy;
        addr_prev = addressed;
    end

    // Read-byte scoreboard: bytes the master saw on the bus versus the queued expectation.
    always @(negedge clk) begin
        if (obs_rd.size() > 0) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got byte 0x%0h, no byte expected", obs_rd.pop_front());
            end else chk("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
        end
    end

    task automatic send_bit(input logic b);
        sda_m = b; #Q; scl = 1'b1; #Q; last_oe = sda_oe; #Q; scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic start_cond();
        if (!scl) begin
            sda_m = 1'b1; #Q; scl = 1'b1; #Q;
        end
        sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_lvl, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        chk(nm, a, exp_lvl);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx);
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
        obs_rd.push_back(b);
        tx_data = next_tx;
        send_bit(mack);
        chk("ack_slot_released", last_oe, 1'b0);
    endtask

    int s_stop, s_tx, s_oe, s_bf, s_ar, s_rx;
    task automatic snap();
        s_stop = n_stop; s_tx = n_txload; s_oe = n_oe_rise;
        s_bf = n_busy_fall; s_ar = n_addr_rise; s_rx = n_rx;
    endtask

    initial begin
        logic dummy;
        #(5*TCLK + 2);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stop_det", stop_det, 0);
        rst_n = 1'b1;
        #(20*TCLK);
        chk("no_spurious_busy", busy, 0);
        chk("no_spurious_stop", n_stop, 0);

        // Write 0x42+W, SDA wiggles while SCL low, data 0xA5, STOP.
        snap();
        exp_rx.push_back(8'hA5);
        start_cond();
        write_byte(8'h84, 1'b0, "t1_addr_ack");
        sda_m = 1'b0; #Q; sda_m = 1'b1; #Q; sda_m = 1'b0; #Q; sda_m = 1'b1; #Q;
        chk("t1_toggle_busy", busy, 1);
        chk("t1_toggle_addressed", addressed, 1);
        chk("t1_toggle_no_stop", n_stop - s_stop, 0);
        write_byte(8'hA5, 1'b0, "t1_data_ack");
        stop_cond();
        chk("t1_oe_pulses", n_oe_rise - s_oe, 2);
        chk("t1_rx_count", n_rx - s_rx, 1);
        chk("t1_addr_rise", n_addr_rise - s_ar, 1);
        chk("t1_stop_count", n_stop - s_stop, 1);
        chk("t1_busy_fall", n_busy_fall - s_bf, 1);
        chk("t1_addressed_end", addressed, 0);

        // Wrong address 0x43+W, data 0x5A.
        snap();
        start_cond();
        write_byte(8'h86, 1'b1, "t2_addr_nack");
        write_byte(8'h5A, 1'b1, "t2_data_nack");
        stop_cond();
        chk("t2_oe_pulses", n_oe_rise - s_oe, 0);
        chk("t2_rx_count", n_rx - s_rx, 0);
        chk("t2_addr_rise", n_addr_rise - s_ar, 0);
        chk("t2_stop_count", n_stop - s_stop, 1);

        // Read 0x42+R: 0x3C then 0xC3, master ACK then NACK.
        snap();
        tx_data = 8'h3C;
        exp_rd.push_back(8'h3C);
        exp_rd.push_back(8'hC3);
        start_cond();
        write_byte(8'h85, 1'b0, "t3_addr_ack");
        read_byte(1'b0, 8'hC3);
        read_byte(1'b1, 8'hC3);
        chk("t3_ignore_released", sda_oe, 0);
        stop_cond();
        chk("t3_tx_load_count", n_txload - s_tx, 2);
        chk("t3_oe_pulses", n_oe_rise - s_oe, 3);
        chk("t3_stop_count", n_stop - s_stop, 1);
        chk("t3_rd_drained", exp_rd.size(), 0);

        // Write 0x11, repeated START, write 0x22, STOP.
        snap();
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        start_cond();
        write_byte(8'h84, 1'b0, "t4_addr1_ack");
        write_byte(8'h11, 1'b0, "t4_data1_ack");
        start_cond();
        chk("t4_busy_rstart", busy, 1);
        write_byte(8'h84, 1'b0, "t4_addr2_ack");
        write_byte(8'h22, 1'b0, "t4_data2_ack");
        stop_cond();
        chk("t4_rx_count", n_rx - s_rx, 2);
        chk("t4_busy_fall", n_busy_fall - s_bf, 1);
        chk("t4_stop_count", n_stop - s_stop, 1);
        chk("t4_addr_rise", n_addr_rise - s_ar, 2);

        // Reset during bit 4 of a read byte (DUT pulling SDA), then a full write of 0x77.
        tx_data = 8'h00;
        start_cond();
        write_byte(8'h85, 1'b0, "t5_addr_ack");
        for (int i = 0; i < 3; i++) recv_bit(dummy);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q;
        chk("t5_oe_before_rst", sda_oe, 1);
        rst_n = 1'b0;
        #TCLK;
        chk("t5_rst_sda_oe", sda_oe, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_addressed", addressed, 0);
        chk("t5_rst_rx_data", rx_data, 8'h00);
        #(Q - TCLK); scl = 1'b0; #Q;
        recv_bit(dummy);
        rst_n = 1'b1;
        recv_bit(dummy);
        recv_bit(dummy);
        send_bit(1'b1);
        chk("t5_idle_after_rst", busy, 0);
        snap();
        exp_rx.push_back(8'h77);
        start_cond();
        write_byte(8'h84, 1'b0, "t5_addr_ack2");
        write_byte(8'h77, 1'b0, "t5_data_ack");
        stop_cond();
        chk("t5_rx_count", n_rx - s_rx, 1);
        chk("t5_stop_count", n_stop - s_stop, 1);
        chk("rx_drained", exp_rx.size(), 0);
        chk("oe_change_scl_high", n_viol, 0);

        #(10*TCLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
